// File: rtl/dma_transfer_sequencer_if.sv
// Bus-side signals of the DMA sequencer: DREQ/DACK, HRQ/HLDA, READY,
// address strobe and the four active-low command strobes.
interface dma_transfer_sequencer_if;
  logic [3:0] dma_request;
  logic [3:0] dma_acknowledge_n;
  logic       hold_request;
  logic       hold_acknowledge;
  logic       ready;
  logic       address_strobe;
  logic [1:0] active_channel;
  logic       io_read_n;
  logic       io_write_n;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       terminal_count;

  modport master (
    input  dma_request, hold_acknowledge, ready,
    output dma_acknowledge_n, hold_request, address_strobe, active_channel,
           io_read_n, io_write_n, memory_read_n, memory_write_n, terminal_count
  );

  modport slave (
    output dma_request, hold_acknowledge, ready,
    input  dma_acknowledge_n, hold_request, address_strobe, active_channel,
           io_read_n, io_write_n, memory_read_n, memory_write_n, terminal_count
  );
endinterface

// File: rtl/dma_transfer_sequencer.sv
// Single-transfer DMA sequencer for four XT-style channels: priority resolve,
// HRQ/HLDA handshake, one S0..S4 bus cycle per grant, per-channel counters with TC.
module dma_transfer_sequencer #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  dma_transfer_sequencer_if.master  bus,
  input  logic [3:0]                external_mask,
  input  logic                      rotating_priority,
  input  logic [3:0]                channel_to_memory,
  input  logic                      count_load,
  input  logic [1:0]                count_channel,
  input  logic [COUNT_WIDTH-1:0]    count_value,
  output logic [3:0]                tc_status,
  output logic [3:0]                auto_mask
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_S4   = 3'd5
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [1:0]             channel_r;
  logic [1:0]             priority_r;
  logic                   to_memory_r;
  logic [1:0]             base_s;
  logic [1:0]             winner_s;
  logic [3:0]             eligible_s;
  logic                   any_eligible_s;
  logic [3:0]             tc_status_r;
  logic [3:0]             auto_mask_r;
  logic [COUNT_WIDTH-1:0] count_r [4];

  logic       hold_request_s;
  logic [3:0] dack_n_s;
  logic       address_strobe_s;
  logic       io_read_n_s;
  logic       io_write_n_s;
  logic       memory_read_n_s;
  logic       memory_write_n_s;
  logic       terminal_count_s;

  // Eligible requests and the winner; the downward scan leaves the lowest offset from base
  always_comb begin
    eligible_s     = bus.dma_request & ~external_mask & ~auto_mask_r;
    any_eligible_s = |eligible_s;
    base_s         = rotating_priority ? priority_r : 2'd0;
    winner_s       = base_s;
    for (int k = 3; k >= 0; k--) begin
      if (eligible_s[base_s + 2'(k)]) begin
        winner_s = base_s + 2'(k);
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // State register, granted channel, latched direction and rotation pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      channel_r   <= 2'd0;
      to_memory_r <= 1'b0;
      priority_r  <= 2'd0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == ST_IDLE) && (state_next_s == ST_S0)) begin
        channel_r   <= winner_s;
        to_memory_r <= channel_to_memory[winner_s];
      end
      if (state_r == ST_S4) begin
        priority_r <= channel_r + 2'd1;
      end
    end
  end

  // Next-state logic; once past S0 the cycle runs to completion
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_eligible_s) begin
          state_next_s = ST_S0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_S0: begin
        if (!eligible_s[channel_r]) begin
          state_next_s = ST_IDLE;
        end else if (bus.hold_acknowledge) begin
          state_next_s = ST_S1;
        end else begin
          state_next_s = ST_S0;
        end
      end
      ST_S1:   state_next_s = ST_S2;
      ST_S2:   state_next_s = ST_S3;
      ST_S3: begin
        if (bus.ready) begin
          state_next_s = ST_S4;
        end else begin
          state_next_s = ST_S3;
        end
      end
      ST_S4:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Moore output decode from registered state, channel and direction
  always_comb begin
    hold_request_s   = (state_r != ST_IDLE);
    dack_n_s         = 4'hF;
    address_strobe_s = (state_r == ST_S1);
    io_read_n_s      = 1'b1;
    io_write_n_s     = 1'b1;
    memory_read_n_s  = 1'b1;
    memory_write_n_s = 1'b1;
    terminal_count_s = 1'b0;
    case (state_r)
      ST_S1: dack_n_s[channel_r] = 1'b0;
      ST_S2: begin
        dack_n_s[channel_r] = 1'b0;
        io_read_n_s         = ~to_memory_r;
        memory_read_n_s     = to_memory_r;
      end
      ST_S3: begin
        dack_n_s[channel_r] = 1'b0;
        io_read_n_s         = ~to_memory_r;
        memory_read_n_s     = to_memory_r;
        memory_write_n_s    = ~to_memory_r;
        io_write_n_s        = to_memory_r;
      end
      ST_S4: begin
        dack_n_s[channel_r] = 1'b0;
        terminal_count_s    = (count_r[channel_r] == {COUNT_WIDTH{1'b0}});
      end
      default: dack_n_s = 4'hF;
    endcase
  end

  // Transfer counters, sticky TC flags and auto-mask; a load beats the S4 decrement
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        count_r[i] <= {COUNT_WIDTH{1'b0}};
      end
      tc_status_r <= 4'h0;
      auto_mask_r <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (count_load && (count_channel == 2'(i))) begin
          count_r[i]     <= count_value;
          tc_status_r[i] <= 1'b0;
          auto_mask_r[i] <= 1'b0;
        end else if ((state_r == ST_S4) && (channel_r == 2'(i))) begin
          count_r[i] <= count_r[i] - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          if (count_r[i] == {COUNT_WIDTH{1'b0}}) begin
            tc_status_r[i] <= 1'b1;
            auto_mask_r[i] <= 1'b1;
          end else begin
            tc_status_r[i] <= tc_status_r[i];
            auto_mask_r[i] <= auto_mask_r[i];
          end
        end else begin
          count_r[i] <= count_r[i];
        end
      end
    end
  end

  assign bus.hold_request      = hold_request_s;
  assign bus.dma_acknowledge_n = dack_n_s;
  assign bus.address_strobe    = address_strobe_s;
  assign bus.active_channel    = channel_r;
  assign bus.io_read_n         = io_read_n_s;
  assign bus.io_write_n        = io_write_n_s;
  assign bus.memory_read_n     = memory_read_n_s;
  assign bus.memory_write_n    = memory_write_n_s;
  assign bus.terminal_count    = terminal_count_s;
  assign tc_status             = tc_status_r;
  assign auto_mask             = auto_mask_r;

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Directed bench for dma_transfer_sequencer: expected grants and TC flags are
// queued from a counter model as requests are raised and popped at each S1.
module tb_dma_transfer_sequencer;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    external_mask;
  logic          rotating_priority;
  logic [3:0]    channel_to_memory;
  logic          count_load;
  logic [1:0]    count_channel;
  logic [CW-1:0] count_value;
  logic [3:0]    tc_status;
  logic [3:0]    auto_mask;

  dma_transfer_sequencer_if bus ();

  dma_transfer_sequencer #(.COUNT_WIDTH(CW)) dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .external_mask     (external_mask),
    .rotating_priority (rotating_priority),
    .channel_to_memory (channel_to_memory),
    .count_load        (count_load),
    .count_channel     (count_channel),
    .count_value       (count_value),
    .tc_status         (tc_status),
    .auto_mask         (auto_mask)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] channel;
    logic       tc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned model_count [4];
  int          tests_run    = 0;
  int          tests_failed = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] dack_of(input logic [1:0] ch);
    logic [3:0] v;
    v     = 4'hF;
    v[ch] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] strobes();
    return {bus.io_read_n, bus.io_write_n, bus.memory_read_n, bus.memory_write_n};
  endfunction

  task automatic push_exp(input logic [1:0] ch);
    exp_t e;
    e.channel = ch;
    e.tc      = (model_count[ch] == 0);
    model_count[ch] = (model_count[ch] - 1) & 32'h0000_FFFF;
    exp_q.push_back(e);
  endtask

  task automatic load_count(input logic [1:0] ch, input logic [CW-1:0] val);
    count_load    = 1'b1;
    count_channel = ch;
    count_value   = val;
    tick();
    count_load    = 1'b0;
    model_count[ch] = val;
  endtask

  task automatic do_reset();
    reset                = 1'b1;
    bus.dma_request      = 4'h0;
    bus.hold_acknowledge = 1'b0;
    bus.ready            = 1'b1;
    count_load           = 1'b0;
    rotating_priority    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_count[i] = 0;
    exp_q.delete();
  endtask

  task automatic wait_hrq();
    int n;
    n = 0;
    while (!bus.hold_request && n < 20) begin
      tick();
      n++;
    end
    check("hrq_wait", bus.hold_request, 1'b1);
  endtask

  // One full grant: HLDA after hack_delay cycles, 'waits' wait states, optional S4 load
  task automatic serve(input int hack_delay, input int waits, input bit do_load,
                       input logic [CW-1:0] load_val);
    exp_t       e;
    logic [3:0] s2_exp;
    logic [3:0] s3_exp;
    logic       wr;
    int         low_cycles;
    wait_hrq();
    repeat (hack_delay) tick();
    bus.hold_acknowledge = 1'b1;
    bus.ready            = (waits == 0);
    tick();
    bus.hold_acknowledge = 1'b0;
    check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("s1_address_strobe", bus.address_strobe, 1'b1);
    check("s1_active_channel", bus.active_channel, e.channel);
    check("s1_dack_n", bus.dma_acknowledge_n, dack_of(e.channel));
    check("s1_strobes", strobes(), 4'b1111);
    s2_exp = channel_to_memory[e.channel] ? 4'b0111 : 4'b1101;
    s3_exp = channel_to_memory[e.channel] ? 4'b0110 : 4'b1001;
    tick();
    check("s2_strobes", strobes(), s2_exp);
    check("s2_address_strobe", bus.address_strobe, 1'b0);
    tick();
    low_cycles = 0;
    for (int w = 0; w <= waits; w++) begin
      check("s3_strobes", strobes(), s3_exp);
      wr = channel_to_memory[e.channel] ? bus.memory_write_n : bus.io_write_n;
      if (wr == 1'b0) low_cycles++;
      if (w == waits) bus.ready = 1'b1;
      if (w < waits) tick();
    end
    check("s3_write_low_cycles", low_cycles, waits + 1);
    tick();
    check("s4_strobes", strobes(), 4'b1111);
    check("s4_dack_n", bus.dma_acknowledge_n, dack_of(e.channel));
    check("s4_terminal_count", bus.terminal_count, e.tc);
    if (do_load) begin
      count_load    = 1'b1;
      count_channel = e.channel;
      count_value   = load_val;
    end
    tick();
    count_load = 1'b0;
    check("idle_hold_request", bus.hold_request, 1'b0);
    check("idle_dack_n", bus.dma_acknowledge_n, 4'hF);
    check("idle_terminal_count", bus.terminal_count, 1'b0);
  endtask

  initial begin
    logic hrq_seen;
    external_mask     = 4'h0;
    channel_to_memory = 4'h0;
    count_channel     = 2'd0;
    count_value       = '0;
    do_reset();

    // Reset state
    check("rst_hold_request", bus.hold_request, 1'b0);
    check("rst_dack_n", bus.dma_acknowledge_n, 4'hF);
    check("rst_strobes", strobes(), 4'b1111);
    check("rst_address_strobe", bus.address_strobe, 1'b0);
    check("rst_terminal_count", bus.terminal_count, 1'b0);
    check("rst_active_channel", bus.active_channel, 2'd0);
    check("rst_tc_status", tc_status, 4'h0);
    check("rst_auto_mask", auto_mask, 4'h0);

    // Three transfers on ch1, TC on the third, then auto-masked
    channel_to_memory = 4'b0010;
    load_count(2'd1, 16'd2);
    bus.dma_request = 4'b0010;
    check("hrq_before_edge", bus.hold_request, 1'b0);
    tick();
    check("hrq_one_cycle_after_dreq", bus.hold_request, 1'b1);
    for (int t = 0; t < 3; t++) push_exp(2'd1);
    for (int t = 0; t < 3; t++) serve(3, 0, 1'b0, '0);
    check("t1_tc_status", tc_status, 4'b0010);
    check("t1_auto_mask", auto_mask, 4'b0010);
    hrq_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      hrq_seen = hrq_seen | bus.hold_request;
    end
    check("t1_no_fourth_hrq", hrq_seen, 1'b0);
    bus.dma_request = 4'h0;
    load_count(2'd1, 16'd9);
    check("reload_clears_tc_status", tc_status, 4'h0);
    check("reload_clears_auto_mask", auto_mask, 4'h0);

    // Fixed priority with all requests held
    do_reset();
    for (int c = 0; c < 4; c++) load_count(2'(c), 16'd100);
    bus.dma_request = 4'b1111;
    for (int t = 0; t < 3; t++) push_exp(2'd0);
    for (int t = 0; t < 3; t++) serve(1, 0, 1'b0, '0);
    bus.dma_request = 4'h0;

    // Rotating priority with all requests held
    do_reset();
    for (int c = 0; c < 4; c++) load_count(2'(c), 16'd100);
    rotating_priority = 1'b1;
    bus.dma_request   = 4'b1111;
    push_exp(2'd0); push_exp(2'd1); push_exp(2'd2); push_exp(2'd3); push_exp(2'd0);
    for (int t = 0; t < 5; t++) serve(1, 0, 1'b0, '0);
    bus.dma_request   = 4'h0;
    rotating_priority = 1'b0;

    // Five wait states on a memory-to-I/O transfer; one decrement only
    do_reset();
    channel_to_memory = 4'b0000;
    load_count(2'd0, 16'd1);
    bus.dma_request = 4'b0001;
    push_exp(2'd0);
    serve(1, 5, 1'b0, '0);
    push_exp(2'd0);
    serve(1, 0, 1'b0, '0);
    bus.dma_request = 4'h0;
    check("wait_auto_mask", auto_mask, 4'b0001);

    // DREQ2 withdrawn in S0 before HLDA
    do_reset();
    load_count(2'd2, 16'd0);
    bus.dma_request = 4'b0100;
    tick();
    check("s0_hold_request", bus.hold_request, 1'b1);
    check("s0_dack_n", bus.dma_acknowledge_n, 4'hF);
    bus.dma_request = 4'h0;
    tick();
    check("abort_hold_request", bus.hold_request, 1'b0);
    check("abort_dack_n", bus.dma_acknowledge_n, 4'hF);
    tick();
    check("abort_dack_n_idle", bus.dma_acknowledge_n, 4'hF);
    check("abort_tc_status", tc_status, 4'h0);
    bus.dma_request = 4'b0100;
    push_exp(2'd2);
    serve(1, 0, 1'b0, '0);
    bus.dma_request = 4'h0;
    check("abort_count_kept_tc", tc_status, 4'b0100);

    // Reset asserted while in S2
    do_reset();
    channel_to_memory = 4'b1000;
    bus.dma_request   = 4'b1000;
    wait_hrq();
    bus.hold_acknowledge = 1'b1;
    tick();
    bus.hold_acknowledge = 1'b0;
    tick();
    check("pre_reset_s2_strobes", strobes(), 4'b0111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_strobes", strobes(), 4'b1111);
    check("mid_reset_dack_n", bus.dma_acknowledge_n, 4'hF);
    check("mid_reset_hold_request", bus.hold_request, 1'b0);
    check("mid_reset_address_strobe", bus.address_strobe, 1'b0);
    check("mid_reset_terminal_count", bus.terminal_count, 1'b0);
    check("mid_reset_tc_status", tc_status, 4'h0);
    for (int i = 0; i < 4; i++) model_count[i] = 0;
    push_exp(2'd3);
    serve(1, 0, 1'b0, '0);
    bus.dma_request = 4'h0;

    // count_load to the active channel in S4 beats the decrement
    do_reset();
    channel_to_memory = 4'b0000;
    load_count(2'd1, 16'd3);
    bus.dma_request = 4'b0010;
    push_exp(2'd1);
    serve(1, 0, 1'b1, 16'd5);
    model_count[1] = 5;
    check("collision_tc_status", tc_status, 4'h0);
    for (int t = 0; t < 6; t++) push_exp(2'd1);
    for (int t = 0; t < 6; t++) serve(1, 0, 1'b0, '0);
    bus.dma_request = 4'h0;
    check("collision_final_tc_status", tc_status, 4'b0010);
    check("collision_final_auto_mask", auto_mask, 4'b0010);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
